// File: rtl/chan_feed_sched.sv
// rtl/chan_feed_sched.sv - multi-image feed/drain sequencer between channel source FIFOs and vip_top
module chan_feed_sched #(
  parameter int DWIDTH      = 32,
  parameter int NUM_CH      = 8,
  parameter int WIDTH       = 28,
  parameter int HEIGHT      = 28,
  parameter int NUM_IMG     = 1,
  parameter int OUT_PER_IMG = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [NUM_CH-1:0]             src_empty,
  input  logic [NUM_CH*DWIDTH-1:0]      src_data,
  output logic [NUM_CH-1:0]             src_rdreq,
  output logic [NUM_CH*DWIDTH-1:0]      fifo_in_data,
  output logic                          fifo_in_wrreq,
  input  logic                          fifo_in_full,
  input  logic [DWIDTH:0]               fifo_out_data,
  input  logic                          fifo_out_empty,
  output logic                          fifo_out_rdreq,
  output logic [DWIDTH:0]               sink_data,
  output logic                          sink_valid,
  input  logic                          sink_ready,
  output logic                          busy,
  output logic [$clog2(NUM_IMG+1)-1:0]  img_idx,
  output logic                          done
);

  localparam int PIX = WIDTH * HEIGHT;
  localparam int PW  = (PIX > 1) ? $clog2(PIX) : 1;
  localparam int OW  = (OUT_PER_IMG > 1) ? $clog2(OUT_PER_IMG) : 1;
  localparam int IW  = $clog2(NUM_IMG + 1);
  localparam logic [PW-1:0] PIX_LAST = PW'(PIX - 1);
  localparam logic [OW-1:0] OUT_LAST = OW'(OUT_PER_IMG - 1);
  localparam logic [IW-1:0] IMG_LAST = IW'(NUM_IMG - 1);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] pix_cnt;
  logic [OW-1:0] out_cnt;
  logic          fire, pop, last_beat, last_pop;

  always_comb begin
    state_nxt = state;
    fire      = 1'b0;
    pop       = 1'b0;
    last_beat = 1'b0;
    last_pop  = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = FEED;
      FEED: begin
        // all channels move together: a single empty channel holds the whole beat
        fire      = (src_empty == '0) && !fifo_in_full;
        last_beat = fire && (pix_cnt == PIX_LAST);
        if (last_beat) state_nxt = DRAIN;
      end
      DRAIN: begin
        pop      = !fifo_out_empty && sink_ready;
        last_pop = pop && (out_cnt == OUT_LAST);
        if (last_pop) state_nxt = (img_idx == IMG_LAST) ? DONE : FEED;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign src_rdreq      = {NUM_CH{fire}};
  assign fifo_in_wrreq  = fire;
  assign fifo_in_data   = fire ? src_data : '0;
  assign fifo_out_rdreq = pop;
  assign busy           = (state != IDLE);
  assign done           = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pix_cnt    <= '0;
      out_cnt    <= '0;
      img_idx    <= '0;
      sink_valid <= 1'b0;
      sink_data  <= '0;
    end else begin
      state      <= state_nxt;
      sink_valid <= pop;
      if (pop) sink_data <= fifo_out_data;
      if (fire) pix_cnt <= last_beat ? '0 : pix_cnt + 1'b1;
      if (pop) out_cnt <= last_pop ? '0 : out_cnt + 1'b1;
      if (last_pop && (img_idx != IMG_LAST)) img_idx <= img_idx + 1'b1;
      if (state == DONE) img_idx <= '0;
    end
  end

endmodule

// File: tb/tb_chan_feed_sched.sv
// tb/tb_chan_feed_sched.sv - self-checking bench for chan_feed_sched
module tb_chan_feed_sched;
  localparam int DW   = 32;
  localparam int NCH  = 8;
  localparam int W    = 4;
  localparam int H    = 4;
  localparam int NIMG = 2;
  localparam int NOUT = 2;
  localparam int PIX  = W * H;
  localparam int IW   = $clog2(NIMG + 1);

  logic              clk, reset, start;
  logic [NCH-1:0]    src_empty, src_rdreq;
  logic [NCH*DW-1:0] src_data, fifo_in_data;
  logic              fifo_in_wrreq, fifo_in_full;
  logic [DW:0]       fifo_out_data, sink_data;
  logic              fifo_out_empty, fifo_out_rdreq, sink_valid, sink_ready;
  logic              busy, done;
  logic [IW-1:0]     img_idx;

  chan_feed_sched #(.DWIDTH(DW), .NUM_CH(NCH), .WIDTH(W), .HEIGHT(H),
                    .NUM_IMG(NIMG), .OUT_PER_IMG(NOUT)) dut (
    .clk(clk), .reset(reset), .start(start),
    .src_empty(src_empty), .src_data(src_data), .src_rdreq(src_rdreq),
    .fifo_in_data(fifo_in_data), .fifo_in_wrreq(fifo_in_wrreq), .fifo_in_full(fifo_in_full),
    .fifo_out_data(fifo_out_data), .fifo_out_empty(fifo_out_empty), .fifo_out_rdreq(fifo_out_rdreq),
    .sink_data(sink_data), .sink_valid(sink_valid), .sink_ready(sink_ready),
    .busy(busy), .img_idx(img_idx), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string name;
    int full_at, full_len;
    int empty_ch, empty_at, empty_len;
    int ready_len;
    bit early, start_mid;
    int exp_beats, exp_words, exp_dones;
  } scen_t;

  int n_cmp = 0, n_bad = 0;
  int act_beats, act_words, act_dones;
  int head_act[NCH], head_exp[NCH];
  logic [DW:0] outq[$];

  // reference model: run bookkeeping by counts
  bit m_run, m_done, m_sv;
  int m_img, m_beats, m_pops;
  logic [DW:0] m_sd;

  function automatic logic [DW-1:0] src_word(input int c, input int n);
    return DW'((c << 28) | (n & 32'h0fff_ffff));
  endfunction

  task automatic chk(input string nm, input logic [255:0] a, input logic [255:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic drive_bench();
    for (int c = 0; c < NCH; c++) src_data[c*DW +: DW] = src_word(c, head_act[c]);
    fifo_out_empty = (outq.size() == 0);
    fifo_out_data  = (outq.size() > 0) ? outq[0] : '0;
  endtask

  task automatic cycle();
    logic efire, epop;
    logic [NCH*DW-1:0] edata;
    logic [NCH-1:0] rd;
    logic orq;
    logic [DW:0] lastw;
    drive_bench();
    @(negedge clk);
    efire = m_run && (m_beats < PIX) && (src_empty == '0) && !fifo_in_full;
    epop  = m_run && (m_beats == PIX) && (m_pops < NOUT) && (outq.size() > 0) && sink_ready;
    edata = '0;
    if (efire) for (int c = 0; c < NCH; c++) edata[c*DW +: DW] = src_word(c, head_exp[c]);
    lastw = (outq.size() > 0) ? outq[0] : '0;
    chk("src_rdreq", src_rdreq, {NCH{efire}});
    chk("fifo_in_wrreq", fifo_in_wrreq, efire);
    if (efire) chk("fifo_in_data", fifo_in_data, edata);
    chk("fifo_out_rdreq", fifo_out_rdreq, epop);
    chk("sink_valid", sink_valid, m_sv);
    if (m_sv) chk("sink_data", sink_data, m_sd);
    chk("busy", busy, m_run || m_done);
    chk("done", done, m_done);
    chk("img_idx", img_idx, m_img);
    if (fifo_in_wrreq) act_beats++;
    if (sink_valid) act_words++;
    if (done) act_dones++;
    rd  = src_rdreq;
    orq = fifo_out_rdreq;
    @(posedge clk);
    #1;
    for (int c = 0; c < NCH; c++) if (rd[c]) head_act[c]++;
    if (orq && outq.size() > 0) void'(outq.pop_front());
    if (efire) for (int c = 0; c < NCH; c++) head_exp[c]++;
    if (reset) begin
      m_run = 0; m_done = 0; m_img = 0; m_beats = 0; m_pops = 0; m_sv = 0; m_sd = '0;
    end else begin
      m_sv = epop;
      if (epop) m_sd = lastw;
      if (efire) m_beats++;
      if (m_done) begin
        m_done = 0; m_img = 0;
      end else if (!m_run && start) begin
        m_run = 1; m_beats = 0; m_pops = 0;
      end
      if (epop) begin
        m_pops++;
        if (m_pops == NOUT) begin
          if (m_img == NIMG - 1) begin
            m_run = 0; m_done = 1;
          end else begin
            m_img++; m_beats = 0; m_pops = 0;
          end
        end
      end
    end
  endtask

  task automatic idle_inputs();
    start = 0; src_empty = '0; fifo_in_full = 0; sink_ready = 1;
  endtask

  task automatic run_scen(input scen_t s);
    int fcnt, ecnt, rcnt, pushed, tot;
    bit finished;
    fcnt = 0; ecnt = 0; rcnt = 0; pushed = 0; finished = 0;
    act_beats = 0; act_words = 0; act_dones = 0;
    idle_inputs();
    start = 1;
    cycle();
    for (int k = 0; k < 800 && !finished; k++) begin
      idle_inputs();
      tot = m_img * PIX + m_beats;
      if (s.full_len > 0 && tot == s.full_at && fcnt < s.full_len) begin
        fifo_in_full = 1; fcnt++;
      end
      if (s.empty_len > 0 && tot == s.empty_at && ecnt < s.empty_len) begin
        src_empty[s.empty_ch] = 1; ecnt++;
      end
      if (m_run && m_beats == PIX && rcnt < s.ready_len) begin
        sink_ready = 0; rcnt++;
      end
      if (m_run && pushed < (m_img + 1) * NOUT && (s.early || m_beats == PIX)) begin
        outq.push_back({1'($urandom_range(0, 1)), DW'($urandom)});
        pushed++;
      end
      start = s.start_mid && m_run && (m_beats == 3);
      cycle();
      if (act_dones > 0) finished = 1;
    end
    if (!finished) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: got no done expected done within budget", s.name);
    end
    idle_inputs();
    cycle();
    chk({s.name, "_beats"}, act_beats, s.exp_beats);
    chk({s.name, "_words"}, act_words, s.exp_words);
    chk({s.name, "_dones"}, act_dones, s.exp_dones);
  endtask

  task automatic run_rand();
    int pushed;
    bit finished;
    pushed = 0; finished = 0;
    act_beats = 0; act_words = 0; act_dones = 0;
    idle_inputs();
    start = 1;
    cycle();
    for (int k = 0; k < 3000 && !finished; k++) begin
      start        = ($urandom_range(0, 7) == 0);
      fifo_in_full = ($urandom_range(0, 3) == 0);
      for (int c = 0; c < NCH; c++) src_empty[c] = ($urandom_range(0, 19) == 0);
      sink_ready   = ($urandom_range(0, 2) != 0);
      if (m_run && pushed < (m_img + 1) * NOUT && ($urandom_range(0, 3) == 0 || m_beats == PIX)) begin
        outq.push_back({1'($urandom_range(0, 1)), DW'($urandom)});
        pushed++;
      end
      cycle();
      if (act_dones > 0) finished = 1;
    end
    if (!finished) begin
      n_cmp++; n_bad++;
      $display("FAIL rand_timeout: got no done expected done within budget");
    end
    idle_inputs();
    cycle();
    chk("rand_beats", act_beats, NIMG * PIX);
    chk("rand_words", act_words, NIMG * NOUT);
  endtask

  scen_t tbl[5];

  initial begin
    tbl[0] = '{"basic",     -1, 0, 0, -1, 0, 0, 1'b0, 1'b0, NIMG*PIX, NIMG*NOUT, 1};
    tbl[1] = '{"full_stall", 6, 5, 0, -1, 0, 0, 1'b0, 1'b0, NIMG*PIX, NIMG*NOUT, 1};
    tbl[2] = '{"ch5_empty", -1, 0, 5,  9, 3, 0, 1'b0, 1'b0, NIMG*PIX, NIMG*NOUT, 1};
    tbl[3] = '{"early_res", -1, 0, 0, -1, 0, 0, 1'b1, 1'b0, NIMG*PIX, NIMG*NOUT, 1};
    tbl[4] = '{"start_rdy", -1, 0, 0, -1, 0, 4, 1'b0, 1'b1, NIMG*PIX, NIMG*NOUT, 1};

    for (int c = 0; c < NCH; c++) begin
      head_act[c] = 0; head_exp[c] = 0;
    end
    m_run = 0; m_done = 0; m_sv = 0; m_img = 0; m_beats = 0; m_pops = 0; m_sd = '0;
    act_beats = 0; act_words = 0; act_dones = 0;
    idle_inputs();
    reset = 1;
    start = 1;
    drive_bench();
    repeat (3) cycle();
    reset = 0;
    idle_inputs();
    cycle();
    chk("rst_sink_data", sink_data, '0);
    chk("rst_busy", busy, 1'b0);

    foreach (tbl[i]) run_scen(tbl[i]);

    // mid-image reset, with start in the same cycle being ignored
    idle_inputs();
    start = 1;
    cycle();
    for (int k = 0; k < 100 && (m_img * PIX + m_beats) < 7; k++) begin
      idle_inputs();
      cycle();
    end
    chk("pre_reset_beats", m_beats, 7);
    idle_inputs();
    reset = 1; start = 1; fifo_in_full = 1;
    cycle();
    reset = 0;
    idle_inputs();
    outq.delete();
    drive_bench();
    chk("rst_mid_sink_data", sink_data, '0);
    chk("rst_mid_sink_valid", sink_valid, 1'b0);
    chk("rst_mid_img_idx", img_idx, '0);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_done", done, 1'b0);
    chk("rst_mid_wrreq", {src_rdreq, fifo_in_wrreq, fifo_out_rdreq}, '0);
    repeat (2) cycle();
    run_scen(tbl[0]);

    for (int r = 0; r < 4; r++) run_rand();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
